// File: rtl/mmm_pkg.sv
// Shared constants, next-PC source encoding and sizing helpers for the
// PC generator with return address stack.
package mmm_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] BOOT_PC = 32'h0000_1000;

  typedef enum logic [2:0] {
    EXCEPT,
    MISPRED,
    RAS,
    PRED,
    SEQ,
    HOLD
  } next_pc_sel_t;

  // Slot index width; a single-wide fetch still carries a 1-bit slot.
  function automatic int slot_w(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 1;
  endfunction

endpackage

// File: rtl/ras.sv
// Circular return address stack: the top pointer wraps, the count saturates
// at RAS_DEPTH, and a push into a full stack overwrites the oldest entry.
module ras #(
  parameter int RAS_DEPTH = 8,
  parameter int XLEN      = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] push_addr_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;

  logic             w_do_pop;
  logic [PTR_W-1:0] w_push_ptr;

  assign empty_o  = (r_count == '0);
  assign full_o   = (r_count == CNT_W'(RAS_DEPTH));
  assign top_o    = r_mem[r_top];
  assign w_do_pop = pop_i && !empty_o;
  // Pop-then-push lands on the current top slot, replacing it in place.
  assign w_push_ptr = w_do_pop ? r_top : r_top + PTR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (push_i && !w_do_pop) begin
      r_top <= w_push_ptr;
      if (!full_o) r_count <= r_count + CNT_W'(1);
    end else if (w_do_pop && !push_i) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  // NOTE: the entry array has no reset; the count alone defines which
  // entries are meaningful, so clearing the storage would buy nothing.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) r_mem[w_push_ptr] <= push_addr_i;
  end

endmodule

// File: rtl/pc_gen_ras_stage.sv
// Fetch-block PC generator: prioritised next-PC mux over exception,
// misprediction, RAS, BTB and sequential sources, with a valid/ready output.
module pc_gen_ras_stage
  import mmm_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int RAS_DEPTH   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             except_i,
  input  logic [XLEN-1:0]                  except_pc_i,
  input  logic                             res_valid_i,
  input  logic                             res_mispredict_i,
  input  logic                             res_taken_i,
  input  logic [XLEN-1:0]                  res_pc_i,
  input  logic [XLEN-1:0]                  res_target_i,
  input  logic                             pred_taken_i,
  input  logic [XLEN-1:0]                  pred_target_i,
  input  logic [slot_w(FETCH_WIDTH)-1:0]   pred_slot_i,
  input  logic                             pred_call_i,
  input  logic                             pred_ret_i,
  input  logic                             fetch_ready_i,
  output logic                             valid_o,
  output logic [XLEN-1:0]                  pc_o,
  output logic                             flush_o
);

  localparam logic [XLEN-1:0] INSN_BYTES  = XLEN'(ILEN / 8);
  localparam logic [XLEN-1:0] BLOCK_BYTES = XLEN'(FETCH_WIDTH * ILEN / 8);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~(BLOCK_BYTES - XLEN'(1));

  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_flush;

  logic            w_fire;
  logic            w_mispred;
  logic            w_redirect;
  logic [XLEN-1:0] w_aligned;
  logic [XLEN-1:0] w_push_addr;
  logic [XLEN-1:0] w_mispred_pc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  next_pc_sel_t    w_sel;
  logic [XLEN-1:0] w_next_pc;

  assign w_fire       = r_valid && fetch_ready_i;
  assign w_mispred    = res_valid_i && res_mispredict_i;
  assign w_redirect   = except_i || w_mispred;
  assign w_aligned    = r_pc & ALIGN_MASK;
  assign w_push_addr  = w_aligned + (XLEN'(pred_slot_i) + XLEN'(1)) * INSN_BYTES;
  assign w_mispred_pc = res_taken_i ? res_target_i : res_pc_i + INSN_BYTES;

  // Redirects squash the RAS side effects of a coincident fire.
  ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_fire && pred_call_i && !w_redirect),
    .pop_i       (w_fire && pred_ret_i && !w_redirect),
    .flush_i     (w_redirect),
    .push_addr_i (w_push_addr),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty),
    .full_o      (w_ras_full)
  );

  // NOTE: every always_comb output gets a default first so no path through
  // the if-chain can leave a latch behind.
  always_comb begin
    w_sel = HOLD;
    if      (except_i)                w_sel = EXCEPT;
    else if (w_mispred)               w_sel = MISPRED;
    else if (w_fire && pred_ret_i)    w_sel = RAS;
    else if (w_fire && pred_taken_i)  w_sel = PRED;
    else if (w_fire)                  w_sel = SEQ;
  end

  always_comb begin
    w_next_pc = r_pc;
    case (w_sel)
      EXCEPT:  w_next_pc = except_pc_i;
      MISPRED: w_next_pc = w_mispred_pc;
      RAS:     w_next_pc = w_ras_empty ? pred_target_i : w_ras_top;
      PRED:    w_next_pc = pred_target_i;
      SEQ:     w_next_pc = w_aligned + BLOCK_BYTES;
      default: w_next_pc = r_pc;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc    <= BOOT_PC;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_valid <= 1'b1;
      r_flush <= w_redirect;
    end
  end

  assign pc_o    = r_pc;
  assign valid_o = r_valid;
  assign flush_o = r_flush;

endmodule
